// File: rtl/multiword_add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// multiword_add_sequencer_pkg
//   Shared definitions for the multi-cycle wide adder front-end:
//   FSM state encoding, the slice adder width and an index-sizing helper.
// ---------------------------------------------------------------------------
package multiword_add_sequencer_pkg;

    // Width of the reusable slice adder; the sequencer's SLICE must match it.
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, never less than 1, so a single-slice build still gets a
    // legal one-bit index register.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/multiword_add_sequencer_ripple_carry_adder.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder
//   Combinational SLICE_W-bit ripple-carry adder used as the shared slice
//   datapath of multiword_add_sequencer.
//
// Ports:
//   a, b  in  [SLICE_W-1:0]  addends
//   cin   in  1              carry into bit 0
//   sum   out [SLICE_W-1:0]  a + b + cin, truncated
//   cout  out 1              carry out of the top bit
// ---------------------------------------------------------------------------
module ripple_carry_adder
    import multiword_add_sequencer_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE_W];

endmodule

// File: rtl/multiword_add_sequencer.sv
// ---------------------------------------------------------------------------
// multiword_add_sequencer
//   Multi-cycle wide adder. Operands accepted over valid/ready are pushed
//   through one shared SLICE-bit ripple-carry adder, LSB slice first, one
//   slice per clock, with the inter-slice carry held in a register. The
//   assembled WIDTH-bit result is offered on a valid/ready output.
//
//   Optional build macro ADD_SUB_SEQ_EN adds a 'sub' input: when set on
//   accept, the block computes a - b (cout=1 means no borrow).
//
// Parameters:
//   WIDTH  operand/result width, integer multiple of SLICE
//   SLICE  slice width, must equal the slice adder width (4)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand offer
//   in_ready   out  block can accept (IDLE only)
//   a, b       in   [WIDTH-1:0] operands, sampled on accept
//   cin        in   carry into slice 0, sampled on accept
//   sub        in   (ADD_SUB_SEQ_EN only) subtract, sampled on accept
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer takes result
//   sum        out  [WIDTH-1:0] registered result
//   cout       out  registered carry-out of the top slice
//   busy       out  high in RUN or DONE
// ---------------------------------------------------------------------------
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SUB_SEQ_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = clog2(NSLICE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    state_t state, state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [IDX_W-1:0] idx;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             last_slice;

    // Operand B and slice-0 carry as they will be latched on accept.
    logic [WIDTH-1:0] b_in;
    logic             carry_in;

`ifdef ADD_SUB_SEQ_EN
    // Two's-complement subtract: a + ~b + 1.
    assign b_in     = sub ? ~b : b;
    assign carry_in = sub ? 1'b1 : cin;
`else
    assign b_in     = b;
    assign carry_in = cin;
`endif

    assign slice_a    = a_q[idx*SLICE +: SLICE];
    assign slice_b    = b_q[idx*SLICE +: SLICE];
    assign last_slice = (idx == IDX_LAST);

    ripple_carry_adder u_slice_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent
    // races between always_ff blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_slice) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Returning to IDLE first means in_ready only rises the cycle
                // after the result is taken: no same-cycle re-accept.
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b_in;
                        carry <= carry_in;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_q[idx*SLICE +: SLICE] <= slice_sum;
                    carry                     <= slice_cout;
                    if (last_slice) begin
                        cout_q <= slice_cout;
                        idx    <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    // DONE holds sum and cout stable until handed off.
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
